// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared RV32M divide encodings, widths and FSM state type
package div_sequencer_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 5;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;
endpackage

// File: rtl/div_iter_core.sv
// div_iter_core: radix-2 restoring shift-subtract datapath on unsigned magnitudes
//   clk, rst  clock, async active-high reset
//   load      capture a_abs as quotient seed, b_abs as divisor, clear remainder
//   step      perform one shift-subtract iteration
//   q, r      current quotient and remainder
module div_iter_core
  import div_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] a_abs,
  input  logic [XLEN-1:0] b_abs,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);
  logic [XLEN:0] rem, sh, trial;
  logic [XLEN-1:0] quot, dvs;
  always_comb begin
    sh = {rem[XLEN-1:0], quot[XLEN-1]};
    trial = sh - {1'b0, dvs};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      quot <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quot <= a_abs;
      dvs <= b_abs;
    end else if (step) begin
      // a negative trial (borrow out of the top bit) means restore
      rem <= trial[XLEN] ? sh : trial;
      quot <= {quot[XLEN-2:0], ~trial[XLEN]};
    end
  end
  assign q = quot;
  assign r = rem[XLEN-1:0];
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: sequences the iterative divider for RV32M DIV/DIVU/REM/REMU in EX
//   clk, rst      clock, async active-high reset
//   start_valid   EX holds a divide op; func = funct3[1:0]
//   rs1/rs2_data  dividend / divisor, sampled only in the start cycle
//   flush         mispredict kill of EX, outranks everything including the result pulse
//   stall         freeze IF/ID/EX while the divide is pending
//   busy          FSM not idle
//   result_valid  one-cycle pulse with signed-corrected quotient or remainder on result
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  input  logic [1:0]      func,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);
  div_state_e state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0] fn;
  logic q_neg, r_neg, spec, sgn, div0, ovf, go;
  logic [XLEN-1:0] sq, sr, a_abs, b_abs, q, r, qv, rv;
  always_comb begin
    sgn = ~func[0];
    a_abs = (sgn & rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    b_abs = (sgn & rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
    div0 = rs2_data == '0;
    ovf = sgn & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data);
    go = (state == IDLE) & start_valid & ~flush;
  end
  always_comb begin
    nxt = IDLE;
    if (!flush)
      nxt = state == IDLE ? (start_valid ? ((div0 | ovf) ? DONE : RUN) : IDLE) :
            state == RUN  ? (cnt == '0 ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      fn <= '0;
      spec <= 1'b0;
      sq <= '0;
      sr <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      state <= nxt;
      if (go) begin
        cnt <= CNT_W'(XLEN-1);
        fn <= func;
        spec <= div0 | ovf;
        sq <= div0 ? '1 : rs1_data;
        sr <= div0 ? rs1_data : '0;
        // special cases return raw values, so sign restore is suppressed for them
        q_neg <= ~(div0 | ovf) & sgn & (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
        r_neg <= ~(div0 | ovf) & sgn & rs1_data[XLEN-1];
      end else if (state == RUN && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end
  div_iter_core u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (go & ~(div0 | ovf)),
    .step  (state == RUN),
    .a_abs (a_abs),
    .b_abs (b_abs),
    .q     (q),
    .r     (r)
  );
  always_comb begin
    qv = spec ? sq : q;
    rv = spec ? sr : r;
    stall = go | (state == RUN);
    busy = state != IDLE;
    result_valid = (state == DONE) & ~flush;
    result = result_valid ? (fn[1] ? (r_neg ? -rv : rv) : (q_neg ? -qv : qv)) : '0;
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer
module tb_div_sequencer;
  logic clk = 0, rst = 1, start_valid = 0, flush = 0;
  logic [1:0] func = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0;
  logic stall, busy, result_valid;
  logic [31:0] result;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  div_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .func         (func),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input string tag, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int lat);
    int n = 0;
    logic sok = 1;
    chk({tag, " idle"}, {31'b0, busy}, 0);
    start_valid = 1;
    func = f;
    rs1_data = a;
    rs2_data = b;
    #1;
    chk({tag, " stall_start"}, {31'b0, stall}, 1);
    do begin
      tick();
      rs1_data = ~a;
      rs2_data = b + 32'd3;
      n++;
      if (!result_valid) sok &= stall;
    end while (!result_valid && n < 40);
    chk({tag, " stall_hold"}, {31'b0, sok}, 1);
    chk({tag, " latency"}, n, lat);
    chk({tag, " result"}, result, exp);
    chk({tag, " stall_done"}, {31'b0, stall}, 0);
    start_valid = 0;
    tick();
    chk({tag, " pulse"}, {31'b0, result_valid}, 0);
  endtask
  initial begin
    int seen;
    #12;
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, result_valid}, 0);
    chk("rst_result", result, 0);
    rst = 0;
    tick();
    op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    op("rem_m20_3", 2'b10, -32'sd20, 32'd3, 32'hFFFF_FFFE, 33);
    op("div_m20_3", 2'b00, -32'sd20, 32'd3, 32'hFFFF_FFFA, 33);
    op("div_7_m2", 2'b00, 32'd7, -32'sd2, 32'hFFFF_FFFD, 33);
    op("rem_7_m2", 2'b10, 32'd7, -32'sd2, 32'd1, 33);
    op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1);
    op("rem_m5_0", 2'b10, -32'sd5, 32'd0, 32'hFFFF_FFFB, 1);
    op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    op("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    op("remu_max", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);
    op("b2b_a", 2'b01, 32'd1000, 32'd10, 32'd100, 33);
    op("b2b_b", 2'b01, 32'd50, 32'd5, 32'd10, 33);
    start_valid = 1;
    flush = 1;
    func = 2'b01;
    rs1_data = 32'd77;
    rs2_data = 32'd7;
    #1;
    chk("flush_start_stall", {31'b0, stall}, 0);
    tick();
    start_valid = 0;
    flush = 0;
    #1;
    chk("flush_start_busy", {31'b0, busy}, 0);
    start_valid = 1;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    #1;
    tick();
    repeat (11) tick();
    flush = 1;
    #1;
    chk("flush_run_cnt", {27'b0, dut.cnt}, 20);
    tick();
    flush = 0;
    start_valid = 0;
    #1;
    chk("flush_stall", {31'b0, stall}, 0);
    chk("flush_busy", {31'b0, busy}, 0);
    seen = 0;
    repeat (40) begin
      tick();
      seen += int'(result_valid);
    end
    chk("flush_no_valid", seen, 0);
    op("post_flush", 2'b01, 32'd9, 32'd2, 32'd4, 33);
    start_valid = 1;
    func = 2'b00;
    rs1_data = 32'd999;
    rs2_data = 32'd4;
    #1;
    tick();
    repeat (5) tick();
    start_valid = 0;
    rst = 1;
    #1;
    chk("rst_mid_stall", {31'b0, stall}, 0);
    chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_valid", {31'b0, result_valid}, 0);
    chk("rst_mid_result", result, 0);
    tick();
    rst = 0;
    tick();
    op("post_rst", 2'b00, -32'sd100, 32'd7, 32'hFFFF_FFF2, 33);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
